// File: rtl/mpu_fetch.sv
// rtl/mpu_fetch.sv - MPU instruction fetch sequencer assembling a 6-byte decode window at pc
// Define MPU_FETCH_COUNT_EN to add the 32-bit accepted-instruction counter output icount.
module mpu_fetch #(
    parameter logic [15:0] START_ADDR = 16'h0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    input  logic [7:0]  mem_data,
    output logic [47:0] i,
    output logic        i_valid,
    input  logic        i_ready,
    input  logic [15:0] isize,
    input  logic        error,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    output logic [15:0] pc,
`ifdef MPU_FETCH_COUNT_EN
    output logic [31:0] icount,
`endif
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, FILL, READY, FAULT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  req;
    logic [2:0]  cnt_nxt;
    logic [2:0]  req_nxt;
    logic [15:0] pc_nxt;
    logic [15:0] addr_nxt;
    logic [47:0] win_nxt;
    logic [2:0]  sz;
    logic        pend;
    logic        accept;
    logic        issue;

    // i_valid follows the decoder combinationally so a bad opcode is never offered
    assign i_valid = (state == READY) && !error;
    assign accept  = i_valid && i_ready;
    assign sz      = (isize > 16'd6) ? 3'd6 : isize[2:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = req;
        pc_nxt    = pc;
        win_nxt   = i;
        case (state)
            IDLE: begin
                if (en) state_nxt = FILL;
            end
            FILL: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                    req_nxt   = 3'd0;
                    win_nxt   = '0;
                end else begin
                    if (pend) begin
                        for (int k = 0; k < 6; k++) begin
                            if (cnt == 3'(k)) win_nxt[8*k +: 8] = mem_data;
                        end
                        cnt_nxt = cnt + 3'd1;
                    end
                    if (cnt_nxt == 3'd6) state_nxt = READY;
                end
            end
            READY: begin
                if (error) begin
                    state_nxt = FAULT;
                end else begin
                    if (accept) begin
                        state_nxt = FILL;
                        if (jmp) begin
                            pc_nxt  = jmp_addr;
                            cnt_nxt = 3'd0;
                            req_nxt = 3'd0;
                            win_nxt = '0;
                        end else begin
                            // keep the bytes past this instruction, refetch only the tail
                            pc_nxt  = pc + isize;
                            win_nxt = i >> {sz, 3'b000};
                            cnt_nxt = 3'd6 - sz;
                            req_nxt = 3'd6 - sz;
                        end
                    end
                    if (!en) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 3'd0;
                        req_nxt   = 3'd0;
                        win_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = FAULT;
            end
        endcase
        issue    = (state_nxt == FILL) && (req_nxt < 3'd6);
        addr_nxt = pc_nxt + {13'd0, req_nxt};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            pc       <= START_ADDR;
            i        <= '0;
            cnt      <= 3'd0;
            req      <= 3'd0;
            pend     <= 1'b0;
            mem_re   <= 1'b0;
            mem_addr <= 16'h0000;
            fault    <= 1'b0;
`ifdef MPU_FETCH_COUNT_EN
            icount   <= 32'd0;
`endif
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            i      <= win_nxt;
            cnt    <= cnt_nxt;
            req    <= req_nxt + {2'd0, issue};
            pend   <= mem_re;
            mem_re <= issue;
            if (issue) mem_addr <= addr_nxt;
            if (state_nxt == FAULT) fault <= 1'b1;
`ifdef MPU_FETCH_COUNT_EN
            if (accept) icount <= icount + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_mpu_fetch.sv
// tb/tb_mpu_fetch.sv - directed table and sequence bench for mpu_fetch
module tb_mpu_fetch;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        en = 1'b0;
    logic        i_ready = 1'b0;
    logic        jmp = 1'b0;
    logic [15:0] jmp_addr = 16'h0000;
    logic [15:0] mem_addr;
    logic [15:0] pc;
    logic [15:0] isize;
    logic        mem_re;
    logic        i_valid;
    logic        error;
    logic        fault;
    logic [7:0]  mem_data;
    logic [47:0] i;
`ifdef MPU_FETCH_COUNT_EN
    logic [31:0] icount;
`endif
    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        re;
        logic [15:0] addr;
        logic        v;
        logic [15:0] pc;
        logic        ci;
        logic [47:0] iv;
    } vec_t;

    vec_t tbl [13];

    mpu_fetch #(.START_ADDR(16'h0010)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .en       (en),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_data (mem_data),
        .i        (i),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .isize    (isize),
        .error    (error),
        .jmp      (jmp),
        .jmp_addr (jmp_addr),
        .pc       (pc),
`ifdef MPU_FETCH_COUNT_EN
        .icount   (icount),
`endif
        .fault    (fault)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (mem_re) mem_data <= mem[mem_addr];
    end

    always_comb begin
        isize = 16'd1;
        error = (i[7:0] == 8'h00);
        case (i[7:0])
            8'hC3:   isize = 16'd2;
            8'hE2:   isize = 16'd6;
            8'h44:   isize = 16'd4;
            default: isize = 16'd1;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic accept(input logic j, input logic [15:0] ja, input logic [15:0] exp_pc);
        chk("pre_accept_valid", 64'(i_valid), 64'd1);
        i_ready  = 1'b1;
        jmp      = j;
        jmp_addr = ja;
        step();
        i_ready = 1'b0;
        jmp     = 1'b0;
        n_acc++;
        chk("accept_pc", 64'(pc), 64'(exp_pc));
`ifdef MPU_FETCH_COUNT_EN
        chk("icount", 64'(icount), 64'(n_acc));
`endif
    endtask

    task automatic expect_fill(input logic [15:0] base, input int n, input logic exp_v);
        logic [15:0] a;
        for (int k = 0; k < n; k++) begin
            a = base + 16'(k);
            chk("fill_re", 64'(mem_re), 64'd1);
            chk("fill_addr", 64'(mem_addr), 64'(a));
            step();
        end
        chk("fill_gap_re", 64'(mem_re), 64'd0);
        chk("fill_gap_valid", 64'(i_valid), 64'd0);
        step();
        chk("fill_valid", 64'(i_valid), 64'(exp_v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h41;
        mem[16'h0010] = 8'hC3; mem[16'h0011] = 8'h11; mem[16'h0012] = 8'hE2;
        mem[16'h0013] = 8'h22; mem[16'h0014] = 8'h33; mem[16'h0015] = 8'h44;
        mem[16'h0016] = 8'h55; mem[16'h0017] = 8'h66;
        mem[16'hFFFC] = 8'h44; mem[16'hFFFD] = 8'hA1; mem[16'hFFFE] = 8'hA2;
        mem[16'hFFFF] = 8'hA3; mem[16'h0000] = 8'h41; mem[16'h0001] = 8'hB1;
        mem[16'h0002] = 8'hB2; mem[16'h0003] = 8'hB3; mem[16'h0004] = 8'hB4;
        mem[16'h0005] = 8'hB5;
        mem[16'h0200] = 8'hC0; mem[16'h0201] = 8'hC1; mem[16'h0202] = 8'hC2;
        mem[16'h0203] = 8'hD3; mem[16'h0204] = 8'hD4; mem[16'h0205] = 8'hD5;
        mem[16'h0300] = 8'h00;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 48'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0010, 1'b0, 48'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0011, 1'b0, 16'h0010, 1'b0, 48'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'h0012, 1'b0, 16'h0010, 1'b0, 48'h0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'h0013, 1'b0, 16'h0010, 1'b0, 48'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h0014, 1'b0, 16'h0010, 1'b0, 48'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 16'h0015, 1'b0, 16'h0010, 1'b0, 48'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0015, 1'b0, 16'h0010, 1'b0, 48'h0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h0015, 1'b1, 16'h0010, 1'b1, 48'h4433_22E2_11C3};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'h0016, 1'b0, 16'h0012, 1'b0, 48'h0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 16'h0017, 1'b0, 16'h0012, 1'b0, 48'h0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0017, 1'b0, 16'h0012, 1'b0, 48'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0017, 1'b1, 16'h0012, 1'b1, 48'h6655_4433_22E2};

        repeat (2) step();
        sys_rst = 1'b0;
        step();
        chk("rst_i", 64'(i), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);

        for (int r = 0; r < 13; r++) begin
            if (r > 0) step();
            chk("tbl_re", 64'(mem_re), 64'(tbl[r].re));
            chk("tbl_addr", 64'(mem_addr), 64'(tbl[r].addr));
            chk("tbl_valid", 64'(i_valid), 64'(tbl[r].v));
            chk("tbl_pc", 64'(pc), 64'(tbl[r].pc));
            if (tbl[r].ci) chk("tbl_i", 64'(i), 64'(tbl[r].iv));
            en      = tbl[r].en;
            i_ready = tbl[r].rdy;
            if (tbl[r].rdy && tbl[r].v) n_acc++;
        end

        accept(1'b0, 16'h0000, 16'h0018);
        expect_fill(16'h0018, 6, 1'b1);
        accept(1'b1, 16'h0100, 16'h0100);
        expect_fill(16'h0100, 6, 1'b1);
        accept(1'b1, 16'hFFFC, 16'hFFFC);
        expect_fill(16'hFFFC, 6, 1'b1);
        chk("wrap_window", 64'(i), 64'h0000_B141_A3A2_A144);
        accept(1'b0, 16'h0000, 16'h0000);
        expect_fill(16'h0002, 4, 1'b1);
        chk("wrap_shift_window", 64'(i), 64'h0000_B5B4_B3B2_B141);

        accept(1'b1, 16'h0200, 16'h0200);
        chk("drop_re0", 64'({mem_re, mem_addr}), 64'h1_0200);
        step();
        chk("drop_re1", 64'({mem_re, mem_addr}), 64'h1_0201);
        step();
        chk("drop_re2", 64'({mem_re, mem_addr}), 64'h1_0202);
        en = 1'b0;
        step();
        chk("idle_re", 64'(mem_re), 64'd0);
        chk("idle_valid", 64'(i_valid), 64'd0);
        chk("idle_pc", 64'(pc), 64'h0200);
        mem[16'h0200] = 8'h41;
        mem[16'h0201] = 8'hE1;
        mem[16'h0202] = 8'hE2;
        step();
        step();
        en = 1'b1;
        step();
        expect_fill(16'h0200, 6, 1'b1);
        chk("refetch_window", 64'(i), 64'h0000_D5D4_D3E2_E141);
        chk("refetch_pc", 64'(pc), 64'h0200);

        accept(1'b1, 16'h0300, 16'h0300);
        expect_fill(16'h0300, 6, 1'b0);
        chk("fault_not_yet", 64'(fault), 64'd0);
        step();
        chk("fault_set", 64'(fault), 64'd1);
        en      = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("fault_sticky", 64'({fault, i_valid, mem_re}), 64'b100);
            if (k == 3) en = 1'b1;
        end
        i_ready = 1'b0;

        #2;
        sys_rst = 1'b1;
        #1;
        chk("rst_fault_clear", 64'(fault), 64'd0);
        chk("rst_fault_pc", 64'(pc), 64'h0010);
        chk("rst_fault_i", 64'(i), 64'd0);
        step();
        sys_rst = 1'b0;
        en = 1'b1;
        step();
        step();
        step();
        chk("mid_fill_re", 64'({mem_re, mem_addr}), 64'h1_0012);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("async_rst_re", 64'(mem_re), 64'd0);
        chk("async_rst_addr", 64'(mem_addr), 64'd0);
        chk("async_rst_pc", 64'(pc), 64'h0010);
        chk("async_rst_i", 64'(i), 64'd0);
        chk("async_rst_valid", 64'(i_valid), 64'd0);
`ifdef MPU_FETCH_COUNT_EN
        chk("async_rst_icount", 64'(icount), 64'd0);
`endif
        step();
        sys_rst = 1'b0;
        en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
